riscv_multicycle_ctrl: RTL and testbench



---
 rtl/riscv_ctrl_pkg.sv | 80 ++++++++
 rtl/riscv_multicycle_ctrl_branch_cond.sv | 19 +
 rtl/riscv_multicycle_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_riscv_multicycle_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control unit: opcodes, FSM states
// and datapath mux select values.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_MEM       = 2'b01,
        RES_ALURESULT = 2'b10,
        RES_IMM       = 2'b11
    } result_src_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    // Full set of datapath controls produced in one state.
    typedef struct packed {
        logic        mem_req;
        logic        mem_write;
        logic        adr_src;
        logic        ir_write;
        logic        pc_write;
        logic        reg_write;
        alu_src_a_t  alu_src_a;
        alu_src_b_t  alu_src_b;
        alu_op_t     alu_op;
        result_src_t result_src;
        imm_src_t    imm_src;
    } ctrl_t;

endpackage

// File: rtl/riscv_multicycle_ctrl_branch_cond.sv
// Branch resolution from funct3 and the ALU zero flag; shared with the
// pipelined core.
module branch_cond
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    output logic       take
);

    always_comb begin
        unique case (funct3)
            F3_BEQ:  take = zero;
            F3_BNE:  take = ~zero;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I control FSM with memory handshake and retired counter.
// Optional build macro CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap instead of acting as NOPs.
module riscv_multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_write,
    output logic               adr_src,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         result_src,
    output logic [2:0]         imm_src,
    output logic [CNT_W-1:0]   instret,
    output logic [STATE_W-1:0] state_o,
    output logic               illegal
);

    state_t state, next_state;
    ctrl_t  ctrl;
    logic   take;
    logic   retire;

    branch_cond u_branch_cond (
        .funct3 (funct3),
        .zero   (zero),
        .take   (take)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            S_FETCH:    if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                unique case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECUTER;
                    OP_ITYPE:          next_state = S_EXECUTEI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_LUI:            next_state = S_LUI;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:           next_state = S_TRAP;
`else
                    default:           next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   next_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
            S_EXECUTER: next_state = S_ALUWB;
            S_EXECUTEI: next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_JAL:      next_state = S_ALUWB;
            S_LUI:      next_state = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP:     next_state = S_TRAP;
`endif
            default:    next_state = S_FETCH;
        endcase
    end

    // Mostly Moore; FETCH and BRANCH also look at mem_ready / take.
    always_comb begin
        ctrl = '0;
        unique case (state)
            S_FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALU_ADD;
                ctrl.result_src = RES_ALURESULT;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_write   = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                if (op == OP_BRANCH)   ctrl.imm_src = IMM_B;
                else if (op == OP_JAL) ctrl.imm_src = IMM_J;
                else                   ctrl.imm_src = IMM_I;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                ctrl.imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_MEM;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.adr_src   = 1'b1;
            end
            S_EXECUTER: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_EXECUTEI: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_FUNCT;
                ctrl.imm_src   = IMM_I;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALU_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = take;
            end
            S_JAL: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALU_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = 1'b1;
            end
            S_LUI: begin
                ctrl.imm_src    = IMM_U;
                ctrl.result_src = RES_IMM;
                ctrl.reg_write  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign mem_req    = ctrl.mem_req;
    assign mem_write  = ctrl.mem_write;
    assign adr_src    = ctrl.adr_src;
    assign ir_write   = ctrl.ir_write;
    assign pc_write   = ctrl.pc_write;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign result_src = ctrl.result_src;
    assign imm_src    = ctrl.imm_src;
    assign state_o    = STATE_W'(state);

    // An instruction retires on the edge that leaves its final state.
    assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_LUI) ||
                    (state == S_BRANCH) || ((state == S_MEMWRITE) && mem_ready);

    always_ff @(posedge clk) begin
        if (reset)       instret <= '0;
        else if (retire) instret <= instret + CNT_W'(1);
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (reset)                     illegal_q <= 1'b0;
        else if (next_state == S_TRAP) illegal_q <= 1'b1;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed table-driven bench for riscv_multicycle_ctrl plus a hand-written
// load-stall sequence; narrow counter so the wrap is reachable.
module tb_riscv_multicycle_ctrl;

    localparam int CNT_W   = 3;
    localparam int STATE_W = 4;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] LU  = 7'b0110111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [6:0]         op = 7'd0;
    logic [2:0]         funct3 = 3'd0;
    logic               zero = 1'b0;
    logic               mem_ready = 1'b0;
    logic               mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]         alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0]         imm_src;
    logic [CNT_W-1:0]   instret;
    logic [STATE_W-1:0] state_o;
    logic               illegal;

    int tests = 0;
    int failed = 0;

    riscv_multicycle_ctrl #(.CNT_W(CNT_W), .STATE_W(STATE_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .imm_src    (imm_src),
        .instret    (instret),
        .state_o    (state_o),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       illegal;
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] aop;
        logic [1:0] res;
        logic [2:0] imm;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       z;
        logic       rdy;
        logic       chk;
        int         st;
        int         ins;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [6:0] o, input logic [2:0] f, input logic z,
                       input logic rdy, input logic chk, input int st, input int ins);
        vec_t v;
        v.rst = r; v.op = o; v.f3 = f; v.z = z; v.rdy = rdy;
        v.chk = chk; v.st = st; v.ins = ins;
        vecs.push_back(v);
    endtask

    // Expected controls per state, straight from the state table.
    function automatic outs_t spec_out(input int st, input logic [6:0] o, input logic [2:0] f,
                                       input logic z, input logic rdy);
        outs_t e;
        e = '0;
        case (st)
            0:  begin e.mem_req = 1; e.b = 2'b10; e.res = 2'b10; e.ir_write = rdy; e.pc_write = rdy; end
            1:  begin e.a = 2'b01; e.b = 2'b01; e.imm = (o == BR) ? 3'b010 : (o == JL) ? 3'b011 : 3'b000; end
            2:  begin e.a = 2'b10; e.b = 2'b01; e.imm = (o == SW) ? 3'b001 : 3'b000; end
            3:  begin e.mem_req = 1; e.adr_src = 1; end
            4:  begin e.res = 2'b01; e.reg_write = 1; end
            5:  begin e.mem_req = 1; e.mem_write = 1; e.adr_src = 1; end
            6:  begin e.a = 2'b10; e.b = 2'b00; e.aop = 2'b10; end
            7:  begin e.a = 2'b10; e.b = 2'b01; e.aop = 2'b10; end
            8:  begin e.reg_write = 1; end
            9:  begin e.a = 2'b10; e.aop = 2'b01; e.pc_write = (f == 3'b000) ? z : (f == 3'b001) ? ~z : 1'b0; end
            10: begin e.a = 2'b01; e.b = 2'b10; e.pc_write = 1; end
            11: begin e.imm = 3'b100; e.res = 2'b11; e.reg_write = 1; end
            12: begin e.illegal = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic outs_t dut_out();
        return {illegal, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, imm_src};
    endfunction

    task automatic wait_state(input logic [3:0] target, input logic rdy, input int budget,
                              input string name);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            mem_ready = rdy;
            #2;
            if (state_o == target) begin
                hit = 1'b1;
                break;
            end
        end
        check(name, 64'(hit), 64'd1);
    endtask

    initial begin
        // lw: FETCH stalls twice, MEMREAD stalls once
        add(1, LW, 0, 0, 0, 0, 0, 0);
        add(0, LW, 0, 0, 0, 1, 0, 0);
        add(0, LW, 0, 0, 0, 1, 0, 0);
        add(0, LW, 0, 0, 1, 1, 0, 0);
        add(0, LW, 0, 0, 0, 1, 1, 0);
        add(0, LW, 0, 0, 0, 1, 2, 0);
        add(0, LW, 0, 0, 0, 1, 3, 0);
        add(0, LW, 0, 0, 1, 1, 3, 0);
        add(0, LW, 0, 0, 0, 1, 4, 0);
        // sw with one MEMWRITE stall
        add(0, SW, 0, 0, 1, 1, 0, 1);
        add(0, SW, 0, 0, 0, 1, 1, 1);
        add(0, SW, 0, 0, 0, 1, 2, 1);
        add(0, SW, 0, 0, 0, 1, 5, 1);
        add(0, SW, 0, 0, 1, 1, 5, 1);
        // R-type
        add(0, RT, 0, 0, 1, 1, 0, 2);
        add(0, RT, 0, 0, 1, 1, 1, 2);
        add(0, RT, 0, 0, 1, 1, 6, 2);
        add(0, RT, 0, 0, 1, 1, 8, 2);
        // beq taken
        add(0, BR, 3'b000, 1, 1, 1, 0, 3);
        add(0, BR, 3'b000, 1, 1, 1, 1, 3);
        add(0, BR, 3'b000, 1, 1, 1, 9, 3);
        // bne with zero=1: not taken
        add(0, BR, 3'b001, 1, 1, 1, 0, 4);
        add(0, BR, 3'b001, 1, 1, 1, 1, 4);
        add(0, BR, 3'b001, 1, 1, 1, 9, 4);
        // jal: four cycles
        add(0, JL, 0, 0, 1, 1, 0, 5);
        add(0, JL, 0, 0, 1, 1, 1, 5);
        add(0, JL, 0, 0, 1, 1, 10, 5);
        add(0, JL, 0, 0, 1, 1, 8, 5);
        // I-type
        add(0, IT, 0, 0, 1, 1, 0, 6);
        add(0, IT, 0, 0, 1, 1, 1, 6);
        add(0, IT, 0, 0, 1, 1, 7, 6);
        add(0, IT, 0, 0, 1, 1, 8, 6);
        // lui: counter at all-ones wraps to 0 on retire
        add(0, LU, 0, 0, 1, 1, 0, 7);
        add(0, LU, 0, 0, 1, 1, 1, 7);
        add(0, LU, 0, 0, 1, 1, 11, 7);
        // unknown opcode
        add(0, BAD, 0, 0, 1, 1, 0, 0);
        add(0, BAD, 0, 0, 1, 1, 1, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        add(0, BAD, 0, 0, 1, 1, 12, 0);
        add(0, BAD, 0, 0, 1, 1, 12, 0);
        add(0, BAD, 0, 0, 0, 1, 12, 0);
        add(1, BAD, 0, 0, 0, 0, 0, 0);
`endif
        add(0, BAD, 0, 0, 0, 1, 0, 0);
        // I-type to make the counter nonzero
        add(0, IT, 0, 0, 1, 1, 0, 0);
        add(0, IT, 0, 0, 1, 1, 1, 0);
        add(0, IT, 0, 0, 1, 1, 7, 0);
        add(0, IT, 0, 0, 1, 1, 8, 0);
        // lw, reset while stalled in MEMREAD
        add(0, LW, 0, 0, 1, 1, 0, 1);
        add(0, LW, 0, 0, 0, 1, 1, 1);
        add(0, LW, 0, 0, 0, 1, 2, 1);
        add(0, LW, 0, 0, 0, 1, 3, 1);
        add(0, LW, 0, 0, 0, 1, 3, 1);
        add(1, LW, 0, 0, 0, 0, 0, 0);
        add(0, LW, 0, 0, 0, 1, 0, 0);
        // branch with unsupported funct3: never taken, still retires
        add(0, BR, 3'b010, 1, 1, 1, 0, 0);
        add(0, BR, 3'b010, 1, 1, 1, 1, 0);
        add(0, BR, 3'b010, 1, 1, 1, 9, 0);
        add(0, BR, 3'b010, 1, 0, 1, 0, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst;
            op = vecs[i].op;
            funct3 = vecs[i].f3;
            zero = vecs[i].z;
            mem_ready = vecs[i].rdy;
            #2;
            if (vecs[i].chk) begin
                check($sformatf("v%0d_state", i), 64'(state_o), 64'(vecs[i].st));
                check($sformatf("v%0d_instret", i), 64'(instret), 64'(vecs[i].ins));
                check($sformatf("v%0d_ctrl", i), 64'(dut_out()),
                      64'(spec_out(vecs[i].st, vecs[i].op, vecs[i].f3, vecs[i].z, vecs[i].rdy)));
            end
        end

        // Hand sequence: long load stalls, handshake drop, single writeback
        begin
            logic bad;
            @(negedge clk);
            reset = 1'b1; mem_ready = 1'b0; op = LW;
            @(negedge clk);
            reset = 1'b0;
            bad = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                mem_ready = 1'b0;
                #2;
                if (state_o != 4'd0 || !mem_req || ir_write || pc_write) bad = 1'b1;
            end
            check("fetch_stall_hold", 64'(bad), 64'd0);
            @(negedge clk);
            mem_ready = 1'b1;
            #2;
            check("fetch_ready_irwrite", 64'(ir_write), 64'd1);
            @(negedge clk);
            mem_ready = 1'b0;
            #2;
            check("decode_after_fetch", 64'(state_o), 64'd1);
            check("mem_req_drop_fetch", 64'(mem_req), 64'd0);
            wait_state(4'd3, 1'b0, 4, "reach_memread");
            bad = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                mem_ready = 1'b0;
                #2;
                if (state_o != 4'd3 || reg_write || !mem_req || mem_write) bad = 1'b1;
            end
            check("memread_stall_hold", 64'(bad), 64'd0);
            @(negedge clk);
            mem_ready = 1'b1;
            #2;
            @(negedge clk);
            mem_ready = 1'b0;
            #2;
            check("memwb_state", 64'(state_o), 64'd4);
            check("memwb_mem_req_drop", 64'(mem_req), 64'd0);
            check("memwb_reg_write", 64'(reg_write), 64'd1);
            @(negedge clk);
            #2;
            check("lw_retired", 64'(instret), 64'd1);
            check("lw_back_fetch", 64'(state_o), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
